// File: rtl/sig_pair_extract_pkg.sv
// Shared definitions for the left/right edge-pair extractor: direction codes,
// side indices, pairing decisions and drop reasons.
package sig_extract_pkg;

  localparam logic DIR_LTR = 1'b0;
  localparam logic DIR_RTL = 1'b1;

  localparam int SIDE_L = 0;
  localparam int SIDE_R = 1;

  typedef enum logic [1:0] {
    DROP_OVF,
    DROP_ORDER,
    DROP_WINDOW
  } drop_reason_e;

  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_ORDER,
    DEC_WINDOW,
    DEC_PAIR
  } decision_e;

  // In LTR the left side takes rising edges and the right side falling ones;
  // RTL swaps the roles.
  function automatic logic edge_qualifies(input logic dir, input int side,
                                          input logic rise, input logic fall);
    if ((side == SIDE_L) == (dir == DIR_LTR)) return rise;
    return fall;
  endfunction

endpackage

// File: rtl/sig_pair_extract_if.sv
// Valid/ready stream carrying one left/right timestamp pair per transfer.
interface sig_pair_extract_if #(
  parameter int TW = 32
);
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] left_time;
  logic [TW-1:0] right_time;

  modport master (output out_valid, left_time, right_time, input out_ready);
  modport slave  (input out_valid, left_time, right_time, output out_ready);
endinterface

// File: rtl/sig_cand_fifo.sv
// Small synchronous candidate FIFO with combinational head so the pairing
// logic can decide on the oldest entry in the cycle after it was written.
module sig_cand_fifo #(
  parameter int TW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [TW-1:0] din,
  output logic [TW-1:0] head,
  output logic          empty,
  output logic          full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage needs no reset; occupancy is tracked solely by count_reg.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  assign head  = mem[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));

endmodule

// File: rtl/sig_pair_extract.sv
// Qualifies left/right edge timestamps against the armed split-sync time,
// queues them per side and pairs lead/lag edges onto a valid/ready stream.
module sig_pair_extract
  import sig_extract_pkg::*;
#(
  parameter int TW     = 32,
  parameter int DEPTH  = 4,
  parameter int MAX_DT = 0,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sync_load,
  input  logic [TW-1:0] sync_time,
  input  logic          dir,
  input  logic [TW-1:0] sig_time_L,
  input  logic          sig_rise_L,
  input  logic          sig_fall_L,
  input  logic [TW-1:0] sig_time_R,
  input  logic          sig_rise_R,
  input  logic          sig_fall_R,
  sig_pair_extract_if.master pair,
  output logic [CW-1:0] drop_ovf,
  output logic [CW-1:0] drop_order,
  output logic [CW-1:0] drop_window,
  output logic          armed
);

  logic [TW-1:0] sync_time_reg;
  logic          dir_reg;
  logic          armed_reg;

  logic          out_valid_reg;
  logic [TW-1:0] left_time_reg;
  logic [TW-1:0] right_time_reg;

  logic [CW-1:0] drop_ovf_reg;
  logic [CW-1:0] drop_order_reg;
  logic [CW-1:0] drop_window_reg;

  logic [TW-1:0] side_time [2];
  logic [1:0]    side_rise;
  logic [1:0]    side_fall;
  logic [1:0]    qual;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    lost;
  logic [1:0]    full;
  logic [1:0]    empty;
  logic [TW-1:0] head [2];

  logic          lead_idx;
  logic          lag_idx;
  logic [TW-1:0] lead_head;
  logic [TW-1:0] lag_head;
  logic          slot_free;
  decision_e     decision;
  logic [1:0]    ovf_inc;

  assign side_time[SIDE_L] = sig_time_L;
  assign side_time[SIDE_R] = sig_time_R;
  assign side_rise = {sig_rise_R, sig_rise_L};
  assign side_fall = {sig_fall_R, sig_fall_L};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      assign qual[gi] = armed_reg && !sync_load
                      && edge_qualifies(dir_reg, gi, side_rise[gi], side_fall[gi])
                      && (side_time[gi] > sync_time_reg);
      // A full FIFO still accepts a push when its head leaves in the same cycle.
      assign push[gi] = qual[gi] && (!full[gi] || pop[gi]);
      assign lost[gi] = qual[gi] && full[gi] && !pop[gi];

      sig_cand_fifo #(
        .TW    (TW),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (sync_load),
        .push    (push[gi]),
        .pop     (pop[gi]),
        .din     (side_time[gi]),
        .head    (head[gi]),
        .empty   (empty[gi]),
        .full    (full[gi])
      );
    end
  endgenerate

  assign lead_idx  = (dir_reg == DIR_LTR) ? 1'(SIDE_R) : 1'(SIDE_L);
  assign lag_idx   = ~lead_idx;
  assign lead_head = head[lead_idx];
  assign lag_head  = head[lag_idx];
  assign slot_free = !out_valid_reg || pair.out_ready;

  always_comb begin
    decision = DEC_NONE;
    pop      = '0;
    if (!sync_load && !empty[0] && !empty[1] && slot_free) begin
      if (lag_head <= lead_head) begin
        decision     = DEC_ORDER;
        pop[lag_idx] = 1'b1;
      end else if (MAX_DT != 0 && (lag_head - lead_head) > TW'(MAX_DT)) begin
        decision      = DEC_WINDOW;
        pop[lead_idx] = 1'b1;
      end else begin
        decision = DEC_PAIR;
        pop      = 2'b11;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_time_reg <= '0;
      dir_reg       <= DIR_LTR;
      armed_reg     <= 1'b0;
    end else if (sync_load) begin
      sync_time_reg <= sync_time;
      dir_reg       <= dir;
      armed_reg     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_reg  <= 1'b0;
      left_time_reg  <= '0;
      right_time_reg <= '0;
    end else if (decision == DEC_PAIR) begin
      out_valid_reg  <= 1'b1;
      left_time_reg  <= head[SIDE_L];
      right_time_reg <= head[SIDE_R];
    end else if (pair.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] c, input logic [1:0] inc);
    logic [CW:0] sum;
    sum = {1'b0, c} + {{(CW-1){1'b0}}, inc};
    return sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
  endfunction

  // Both sides can overflow in the same cycle.
  assign ovf_inc = {1'b0, lost[0]} + {1'b0, lost[1]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_ovf_reg    <= '0;
      drop_order_reg  <= '0;
      drop_window_reg <= '0;
    end else begin
      drop_ovf_reg    <= sat_add(drop_ovf_reg, ovf_inc);
      drop_order_reg  <= sat_add(drop_order_reg, {1'b0, decision == DEC_ORDER});
      drop_window_reg <= sat_add(drop_window_reg, {1'b0, decision == DEC_WINDOW});
    end
  end

  assign pair.out_valid  = out_valid_reg;
  assign pair.left_time  = left_time_reg;
  assign pair.right_time = right_time_reg;
  assign drop_ovf        = drop_ovf_reg;
  assign drop_order      = drop_order_reg;
  assign drop_window     = drop_window_reg;
  assign armed           = armed_reg;

endmodule

// File: tb/tb_sig_pair_extract.sv
// Directed and randomized checks of sig_pair_extract against a queue-based
// model of the pairing rules.
module tb_sig_pair_extract;
  import sig_extract_pkg::*;

  localparam int TW     = 32;
  localparam int DEPTH  = 4;
  localparam int MAX_DT = 20;
  localparam int CW     = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sync_load;
  logic [TW-1:0] sync_time;
  logic          dir;
  logic [TW-1:0] sig_time_L, sig_time_R;
  logic          sig_rise_L, sig_fall_L, sig_rise_R, sig_fall_R;
  logic [CW-1:0] drop_ovf, drop_order, drop_window;
  logic          armed;

  sig_pair_extract_if #(.TW(TW)) pair_if ();

  sig_pair_extract #(
    .TW(TW), .DEPTH(DEPTH), .MAX_DT(MAX_DT), .CW(CW)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sync_load   (sync_load),
    .sync_time   (sync_time),
    .dir         (dir),
    .sig_time_L  (sig_time_L),
    .sig_rise_L  (sig_rise_L),
    .sig_fall_L  (sig_fall_L),
    .sig_time_R  (sig_time_R),
    .sig_rise_R  (sig_rise_R),
    .sig_fall_R  (sig_fall_R),
    .pair        (pair_if),
    .drop_ovf    (drop_ovf),
    .drop_order  (drop_order),
    .drop_window (drop_window),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cov [3];

  // Reference model state
  bit [31:0] q_l[$];
  bit [31:0] q_r[$];
  bit        m_valid, m_armed, m_dir;
  bit [31:0] m_left, m_right, m_sync;
  bit [15:0] m_ovf, m_ord, m_win;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit [15:0] sat(input bit [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  task automatic model_step();
    bit        want_l, want_r, load;
    bit [31:0] lead, lag, nl, nr;
    if (!reset_n) begin
      q_l.delete(); q_r.delete();
      m_valid = 0; m_left = 0; m_right = 0;
      m_ovf = 0; m_ord = 0; m_win = 0;
      m_armed = 0; m_dir = 0; m_sync = 0;
      return;
    end
    if (m_valid && pair_if.out_ready) begin
      $display("pair accepted: left=%0d right=%0d", m_left, m_right);
      m_valid = 0;
    end
    if (sync_load) begin
      m_sync = sync_time; m_dir = dir; m_armed = 1;
      q_l.delete(); q_r.delete();
      return;
    end
    load = 0;
    nl = 0; nr = 0;
    // slot is free if it was empty or just consumed above
    if (q_l.size() > 0 && q_r.size() > 0 && !m_valid) begin
      lead = m_dir ? q_l[0] : q_r[0];
      lag  = m_dir ? q_r[0] : q_l[0];
      if (lag <= lead) begin
        if (m_dir) void'(q_r.pop_front()); else void'(q_l.pop_front());
        m_ord = sat(m_ord); cov[int'(DROP_ORDER)]++;
      end else if (lag - lead > MAX_DT) begin
        if (m_dir) void'(q_l.pop_front()); else void'(q_r.pop_front());
        m_win = sat(m_win); cov[int'(DROP_WINDOW)]++;
      end else begin
        nl = q_l.pop_front(); nr = q_r.pop_front(); load = 1;
      end
    end
    want_l = m_armed && (m_dir ? sig_fall_L : sig_rise_L) && (sig_time_L > m_sync);
    want_r = m_armed && (m_dir ? sig_rise_R : sig_fall_R) && (sig_time_R > m_sync);
    if (want_l) begin
      if (q_l.size() < DEPTH) q_l.push_back(sig_time_L);
      else begin m_ovf = sat(m_ovf); cov[int'(DROP_OVF)]++; end
    end
    if (want_r) begin
      if (q_r.size() < DEPTH) q_r.push_back(sig_time_R);
      else begin m_ovf = sat(m_ovf); cov[int'(DROP_OVF)]++; end
    end
    if (load) begin
      m_valid = 1; m_left = nl; m_right = nr;
    end
  endtask

  task automatic compare_all();
    check("out_valid", pair_if.out_valid, m_valid);
    check("left_time", pair_if.left_time, m_left);
    check("right_time", pair_if.right_time, m_right);
    check("drop_ovf", drop_ovf, m_ovf);
    check("drop_order", drop_order, m_ord);
    check("drop_window", drop_window, m_win);
    check("armed", armed, m_armed);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    sync_load = 0;
    sig_rise_L = 0; sig_fall_L = 0; sig_rise_R = 0; sig_fall_R = 0;
  endtask

  task automatic do_sync(input logic [31:0] t, input logic d);
    sync_load = 1; sync_time = t; dir = d;
    tick();
    sync_load = 0;
  endtask

  task automatic strobe_l(input logic r, input logic f, input logic [31:0] t);
    sig_rise_L = r; sig_fall_L = f; sig_time_L = t;
  endtask

  task automatic strobe_r(input logic r, input logic f, input logic [31:0] t);
    sig_rise_R = r; sig_fall_R = f; sig_time_R = t;
  endtask

  initial begin
    reset_n = 0; sync_time = 0; dir = 0; sig_time_L = 0; sig_time_R = 0;
    pair_if.out_ready = 1;
    idle();
    // Reset state
    tick(); tick();
    check("rst_valid", pair_if.out_valid, 0);
    check("rst_armed", armed, 0);
    check("rst_ovf", drop_ovf, 0);
    reset_n = 1;

    // Unarmed strobes are ignored
    strobe_l(1, 0, 500); strobe_r(0, 1, 400); tick(); idle(); tick(); tick();
    check("unarmed_valid", pair_if.out_valid, 0);
    check("unarmed_order", drop_order, 0);

    // time == sync_time does not qualify
    do_sync(100, DIR_LTR);
    check("armed_set", armed, 1);
    strobe_l(1, 0, 100); strobe_r(0, 1, 100); tick(); idle(); tick(); tick();
    check("eq_sync_valid", pair_if.out_valid, 0);
    check("eq_sync_order", drop_order, 0);

    // LTR basic, gap exactly MAX_DT pairs
    strobe_r(0, 1, 150); tick(); idle();
    strobe_l(1, 0, 170); tick(); idle();
    check("basic_lat", pair_if.out_valid, 0);
    tick();
    check("basic_valid", pair_if.out_valid, 1);
    check("basic_left", pair_if.left_time, 170);
    check("basic_right", pair_if.right_time, 150);
    tick();
    check("basic_consumed", pair_if.out_valid, 0);

    // RTL ordering
    do_sync(150, DIR_RTL);
    strobe_r(1, 0, 200); tick(); idle();
    strobe_l(0, 1, 210); tick(); idle(); tick();
    check("rtl_order", drop_order, 1);
    check("rtl_nopair", pair_if.out_valid, 0);
    strobe_r(1, 0, 230); tick(); idle(); tick();
    check("rtl_valid", pair_if.out_valid, 1);
    check("rtl_left", pair_if.left_time, 210);
    check("rtl_right", pair_if.right_time, 230);
    tick();

    // Window
    do_sync(250, DIR_LTR);
    strobe_r(0, 1, 300); tick(); idle();
    strobe_l(1, 0, 350); tick(); idle(); tick();
    check("win_drop", drop_window, 1);
    strobe_r(0, 1, 360); tick(); idle(); tick();
    strobe_l(1, 0, 370); tick(); idle(); tick();
    check("win_valid", pair_if.out_valid, 1);
    check("win_left", pair_if.left_time, 370);
    check("win_right", pair_if.right_time, 360);
    tick();
    do_sync(380, DIR_LTR);
    strobe_r(0, 1, 400); tick(); idle();
    strobe_l(1, 0, 421); tick(); idle(); tick();
    check("win_21", drop_window, 2);

    // Overflow and back-to-back streaming
    do_sync(500, DIR_LTR);
    pair_if.out_ready = 0;
    for (int k = 0; k < 6; k++) begin
      strobe_r(0, 1, 510 + k); tick();
    end
    idle(); tick();
    check("ovf_count", drop_ovf, 2);
    pair_if.out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      strobe_l(1, 0, 520 + k); tick();
      if (k > 0) begin
        check("stream_valid", pair_if.out_valid, 1);
        check("stream_left", pair_if.left_time, 520 + k - 1);
        check("stream_right", pair_if.right_time, 510 + k - 1);
      end
    end
    idle(); tick();
    check("stream_last_left", pair_if.left_time, 523);
    check("stream_last_right", pair_if.right_time, 513);
    tick();
    check("stream_drained", pair_if.out_valid, 0);

    // Flush keeps pending output
    do_sync(600, DIR_LTR);
    pair_if.out_ready = 0;
    strobe_r(0, 1, 610); tick(); idle();
    strobe_l(1, 0, 620); tick(); idle(); tick();
    strobe_r(0, 1, 630); tick();
    strobe_r(0, 1, 640); tick(); idle();
    do_sync(601, DIR_LTR);
    check("flush_valid", pair_if.out_valid, 1);
    check("flush_left", pair_if.left_time, 620);
    pair_if.out_ready = 1;
    strobe_l(1, 0, 645); tick(); idle(); tick(); tick();
    check("flush_empty", pair_if.out_valid, 0);

    // Reset mid-operation
    reset_n = 0; tick(); reset_n = 1;
    check("rst2_armed", armed, 0);
    check("rst2_ovf", drop_ovf, 0);
    check("rst2_order", drop_order, 0);
    check("rst2_window", drop_window, 0);
    check("rst2_left", pair_if.left_time, 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      idle();
      reset_n = ($urandom_range(0, 799) != 0);
      if ($urandom_range(0, 59) == 0) begin
        sync_load = 1;
        sync_time = 1000 + $urandom_range(0, 100000);
        dir = $urandom_range(0, 1);
      end
      sig_rise_L = ($urandom_range(0, 3) == 0);
      sig_fall_L = ($urandom_range(0, 3) == 0);
      sig_rise_R = ($urandom_range(0, 3) == 0);
      sig_fall_R = ($urandom_range(0, 3) == 0);
      sig_time_L = sync_time + $urandom_range(0, 45) - 4;
      sig_time_R = sync_time + $urandom_range(0, 45) - 4;
      pair_if.out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      tick();
    end
    idle(); reset_n = 1; tick();

    $display("coverage: ovf=%0d order=%0d window=%0d",
             cov[int'(DROP_OVF)], cov[int'(DROP_ORDER)], cov[int'(DROP_WINDOW)]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
